// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the end-of-timestep fire/reset engine.
//   fire_state_t     : scan FSM state encoding
//   RESET_HARD/SOFT  : reset-mode encodings sampled with start_i
//   membrane_max/min : saturation limits of a signed membrane of a given width
// -----------------------------------------------------------------------------
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_EVAL  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } fire_state_t;

    localparam logic RESET_HARD = 1'b0;
    localparam logic RESET_SOFT = 1'b1;

    // Largest value representable by a signed membrane of 'width' bits.
    function automatic longint membrane_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable by a signed membrane of 'width' bits.
    function automatic longint membrane_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/membrane_reset_calc.sv
// -----------------------------------------------------------------------------
// membrane_reset_calc
// Combinational fire decision and reset-membrane computation.
//   i_membrane    : signed membrane value just read from SRAM
//   i_threshold   : signed firing threshold
//   i_mode        : RESET_HARD (reset to 0) or RESET_SOFT (subtract threshold)
//   o_fire        : membrane >= threshold (signed)
//   o_reset_value : value to write back on a fire, saturated to W bits
// -----------------------------------------------------------------------------
module membrane_reset_calc
    import neuron_pkg::*;
#(
    parameter int W = 17
) (
    input  logic signed [W-1:0] i_membrane,
    input  logic signed [W-1:0] i_threshold,
    input  logic                i_mode,
    output logic                o_fire,
    output logic signed [W-1:0] o_reset_value
);

    localparam longint LIM_MAX = membrane_max(W);
    localparam longint LIM_MIN = membrane_min(W);

    logic signed [W:0]   w_diff;
    logic signed [W-1:0] w_soft;

    assign o_fire = (i_membrane >= i_threshold);

    // One extra bit holds the exact difference; only a negative threshold can
    // push it past the positive limit (or a large positive one past the
    // negative limit when the membrane is already very negative).
    assign w_diff = {i_membrane[W-1], i_membrane} - {i_threshold[W-1], i_threshold};

    always_comb begin
        w_soft = w_diff[W-1:0];
        if (longint'(w_diff) > LIM_MAX) begin
            w_soft = LIM_MAX[W-1:0];
        end else if (longint'(w_diff) < LIM_MIN) begin
            w_soft = LIM_MIN[W-1:0];
        end
    end

    always_comb begin
        o_reset_value = '0;
        case (i_mode)
            RESET_HARD: o_reset_value = '0;
            RESET_SOFT: o_reset_value = w_soft;
            default:    o_reset_value = '0;
        endcase
    end

endmodule

// File: rtl/neuron_fire_scan.sv
// -----------------------------------------------------------------------------
// neuron_fire_scan
// Once per timestep, walks every neuron of the membrane SRAM, fires neurons
// whose membrane reaches the threshold, writes back their reset membrane and
// emits the neuron index on a valid/ready spike stream.
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   start_i                 : one-cycle pulse, honoured only when idle
//   threshold_i             : signed threshold, captured on accepted start
//   reset_mode_i            : hard/soft reset mode, captured on accepted start
//   mem_rd_en_o/mem_addr_o  : SRAM read strobe and shared read/write address
//   mem_rd_data_i           : SRAM read data, valid the cycle after the read
//   mem_wr_en_o/_data_o     : SRAM write strobe and reset membrane value
//   spike_valid_o/_addr_o   : spike event and firing neuron index
//   spike_ready_i           : downstream accepts the spike
//   busy_o, done_o          : scan in progress, one-cycle end-of-scan pulse
// Every output is decoded from registered state only.
// -----------------------------------------------------------------------------
module neuron_fire_scan
    import neuron_pkg::*;
#(
    parameter int BIT_WIDTH_MEMBRANE = 17,
    parameter int NEURON_NUM         = 256,
    parameter int BIT_WIDTH_ADDR     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 start_i,
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0] threshold_i,
    input  logic                                 reset_mode_i,
    output logic                                 mem_rd_en_o,
    output logic        [BIT_WIDTH_ADDR-1:0]     mem_addr_o,
    input  logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_rd_data_i,
    output logic                                 mem_wr_en_o,
    output logic signed [BIT_WIDTH_MEMBRANE-1:0] mem_wr_data_o,
    output logic                                 spike_valid_o,
    output logic        [BIT_WIDTH_ADDR-1:0]     spike_addr_o,
    input  logic                                 spike_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int W = BIT_WIDTH_MEMBRANE;
    localparam int A = BIT_WIDTH_ADDR;
    localparam logic [A-1:0] LAST_ADDR = A'(NEURON_NUM - 1);

    fire_state_t         r_state;
    fire_state_t         w_next_state;
    logic [A-1:0]        r_addr;
    logic signed [W-1:0] r_threshold;
    logic                r_mode;
    logic                r_fire_q;
    logic signed [W-1:0] r_reset_val;

    logic                w_fire;
    logic signed [W-1:0] w_reset_val;
    logic                w_last;
    logic                w_advance;

    // The reset value is computed straight from the returning read data, so
    // registering the raw membrane separately is unnecessary.
    membrane_reset_calc #(
        .W (W)
    ) u_reset_calc (
        .i_membrane    (mem_rd_data_i),
        .i_threshold   (r_threshold),
        .i_mode        (r_mode),
        .o_fire        (w_fire),
        .o_reset_value (w_reset_val)
    );

    assign w_last = (r_addr == LAST_ADDR);

    // A neuron is finished when EVAL sees no fire, or the spike is taken.
    assign w_advance = ((r_state == ST_EVAL) && (!r_fire_q || spike_ready_i)) ||
                       ((r_state == ST_HOLD) && spike_ready_i);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ:  w_next_state = ST_LATCH;
            ST_LATCH: w_next_state = ST_EVAL;
            ST_EVAL: begin
                if (r_fire_q && !spike_ready_i) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_HOLD: begin
                if (spike_ready_i) begin
                    w_next_state = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr      <= '0;
            r_threshold <= '0;
            r_mode      <= RESET_HARD;
            r_fire_q    <= 1'b0;
            r_reset_val <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start_i) begin
                r_threshold <= threshold_i;
                r_mode      <= reset_mode_i;
                r_addr      <= '0;
            end
            if (r_state == ST_LATCH) begin
                r_fire_q    <= w_fire;
                r_reset_val <= w_reset_val;
            end
            // Address holds on the last neuron so the DONE cycle still
            // reports the final index.
            if (w_advance && !w_last) begin
                r_addr <= r_addr + A'(1);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_rd_en_o   = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_wr_data_o = '0;
        spike_valid_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        mem_addr_o    = r_addr;
        spike_addr_o  = r_addr;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_READ: begin
                busy_o      = 1'b1;
                mem_rd_en_o = 1'b1;
            end
            ST_LATCH: begin
                busy_o = 1'b1;
            end
            ST_EVAL: begin
                busy_o        = 1'b1;
                // Write happens only in EVAL, so a stalled spike never
                // rewrites the same neuron.
                mem_wr_en_o   = r_fire_q;
                mem_wr_data_o = r_fire_q ? r_reset_val : '0;
                spike_valid_o = r_fire_q;
            end
            ST_HOLD: begin
                busy_o        = 1'b1;
                spike_valid_o = 1'b1;
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/neuron_fire_scan.md
# neuron_fire_scan

End-of-timestep fire/reset engine for the membrane SRAM. Reads each neuron's membrane value written by the accumulate path. Compares it against a threshold. On a fire it writes back the reset membrane value and emits a spike event on a valid/ready stream. It sits between the membrane SRAM and the spike output FIFO and runs once per timestep when `start_i` pulses.

## Interface
- `BIT_WIDTH_MEMBRANE`, 17, signed membrane width
- `NEURON_NUM`, 256, neurons scanned per pass
- `BIT_WIDTH_ADDR`, 8, neuron address width; must satisfy 2^BIT_WIDTH_ADDR >= NEURON_NUM
- `clk_i` in 1: single clock, all logic on rising edge
- `reset_n_i` in 1: reset, asynchronous, active-low
- `start_i` in 1: one-cycle pulse, begins a scan (honoured only in IDLE)
- `threshold_i` in BIT_WIDTH_MEMBRANE: signed threshold, sampled on accepted start
- `reset_mode_i` in 1: 0 = hard reset to 0, 1 = soft reset (subtract threshold); sampled on accepted start
- `mem_rd_en_o` out 1: SRAM read strobe; data returns next cycle
- `mem_addr_o` out BIT_WIDTH_ADDR: SRAM address, for read and write
- `mem_rd_data_i` in BIT_WIDTH_MEMBRANE: signed read data, valid the cycle after `mem_rd_en_o`
- `mem_wr_en_o` out 1: SRAM write strobe
- `mem_wr_data_o` out BIT_WIDTH_MEMBRANE: write data (reset membrane)
- `spike_valid_o` out 1: spike event valid
- `spike_addr_o` out BIT_WIDTH_ADDR: firing neuron index
- `spike_ready_i` in 1: downstream accepts spike
- `busy_o` out 1: scan in progress
- `done_o` out 1: one-cycle pulse at scan end

## Operation
- FSM states: IDLE, READ, LATCH, EVAL, HOLD, DONE.
- **IDLE:** On `start_i`, latch `threshold_i` and `reset_mode_i`, clear the address counter, and go to READ. While busy, `start_i` is ignored in all other states, DONE included.
- **READ:** `mem_rd_en_o`=1 at the current address, then go to LATCH.
- **LATCH:** Register `mem_rd_data_i` into `mem_q`. Register `fire_q` = (`mem_rd_data_i` >= threshold, signed compare). Register the reset value. Go to EVAL.
- **EVAL, when `fire_q`=1:**
  - `mem_wr_en_o`=1 with the reset value for exactly this one cycle.
  - `spike_valid_o`=1 with `spike_addr_o` = the current address.
  - If `spike_ready_i`=1, advance; otherwise go to HOLD.
- **EVAL, when `fire_q`=0:** No write, no spike; advance.
- **HOLD:** Keep `spike_valid_o` and `spike_addr_o` stable. Keep `mem_wr_en_o`=0. Advance when `spike_ready_i`=1.
- **Advance:** If address == NEURON_NUM-1, go to DONE. Otherwise increment the address and go to READ.
- **DONE:** `done_o`=1, then go to IDLE.
- **Reset value, hard mode:** 0.
- **Reset value, soft mode:** `mem_q` − threshold, computed at BIT_WIDTH_MEMBRANE+1 bits and saturated to [−2^(W−1), 2^(W−1)−1]. Overflow occurs only with a negative threshold.
- **Output decoding:** All outputs are decoded from state and registers. There is no combinational path from any input to any output except `mem_rd_data_i` into the LATCH registers.
- **Reset mid-operation:** State returns to IDLE and every output goes to 0. The scan is abandoned, and SRAM contents already written remain. The next `start_i` rescans from address 0.

## Timing
- **Reset values:** every output is 0. `mem_addr_o`=0, `spike_addr_o`=0.
- **Start:** `start_i` is high in IDLE at cycle T. `busy_o` rises at T+1, and READ for address 0 is at T+1.
- **Non-firing neuron:** 3 cycles (READ, LATCH, EVAL).
- **Firing neuron:** 3 cycles plus the number of HOLD cycles.
- **No backpressure:** `done_o` is at cycle T+1+3·NEURON_NUM. `busy_o` is high through the DONE cycle and low the cycle after.
- **Write timing:** the write in EVAL is to the same address as the preceding READ. There is never a read and a write in the same cycle.

## Structure
- Shared package `neuron_pkg` holds:
  - the state enum `fire_state_t`
  - reset-mode constants `RESET_HARD`=0 and `RESET_SOFT`=1
  - the membrane saturation limits as functions of width
- Sub-module `membrane_reset_calc` is combinational:
  - inputs: membrane, threshold, mode
  - outputs: fire flag and saturated reset value
  - it is instantiated once, feeding the LATCH registers.

## Test plan
All scenarios use NEURON_NUM=4, W=17.
- **Hard reset:** SRAM {10,50,−3,99}, threshold 50, hard mode, ready tied 1 → spikes at addr 1 then 3; writes addr1=0, addr3=0; no other writes; `done_o` at T+13.
- **Soft reset:** same data, soft mode → writes addr1=0, addr3=49; SRAM ends {10,0,−3,49}.
- **Backpressure:** ready low for 5 cycles when the addr1 spike appears → `spike_valid_o` is held 6 cycles with addr stable at 1; exactly one write to addr1; no read issued during HOLD; `done_o` is delayed by 5 cycles.
- **Saturation:** threshold −1, soft mode, SRAM {65535,−65536,0,−1} → fires at addr 0, 2, 3; writes 65535 (clamped), 1, 0; addr1 untouched.
- **Reset mid-scan:** `reset_n_i` is low during LATCH of addr 2 → all outputs 0 asynchronously; after release, a new `start_i` reads from addr 0.
- **Start during scan:** `start_i` pulsed in READ and again in DONE → both are ignored; exactly one `done_o`; `busy_o` falls normally.
